// File: rtl/dcm_prog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcm_prog_ctrl : debounced load button -> validated DCM prog_in/update pair |
// | Optional: DCM_PROG_ECHO_CHECK_EN adds a prog_out echo check after holdoff. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dcm_prog_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         HOLD_CYCLES     = 8,
  parameter logic [2:0] MAX_CODE        = 3'd6,
  parameter logic [2:0] RESET_PROG      = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load,
  input  logic [2:0] sel_in,
  input  logic [2:0] prog_echo,
  output logic [2:0] prog_code,
  output logic       update,
  output logic       busy,
  output logic       err,
  output logic [2:0] cur_prog
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

`ifdef DCM_PROG_ECHO_CHECK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    CHECK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic unused_echo;
  assign unused_echo = ^prog_echo;
`endif

  state_t            state;
  logic              sync1, sync2;
  logic              stable, stable_q;
  logic              req;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Synchronizer, debouncer and rising-edge request; a falling edge is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      req      <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_load;
      sync2    <= sync1;
      stable_q <= stable;
      req      <= stable & ~stable_q;
      if (sync2 != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      prog_code <= RESET_PROG;
      cur_prog  <= RESET_PROG;
      update    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (sel_in > MAX_CODE) begin
              err <= 1'b1;
            end else if (sel_in != cur_prog) begin
              prog_code <= sel_in;
              update    <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cur_prog <= prog_code;
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
`ifdef DCM_PROG_ECHO_CHECK_EN
            state    <= CHECK;
`else
            busy     <= 1'b0;
            state    <= IDLE;
`endif
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
`ifdef DCM_PROG_ECHO_CHECK_EN
        // A mismatch is only reported; the issued code stays recorded.
        CHECK: begin
          if (prog_echo != cur_prog) err <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcm_prog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcm_prog_ctrl : directed self-checking bench for dcm_prog_ctrl          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dcm_prog_ctrl;

`ifdef DCM_PROG_ECHO_CHECK_EN
  localparam int EXP_BUSY = 10;
`else
  localparam int EXP_BUSY = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_load = 1'b0;
  logic [2:0] sel_in = 3'd0;
  logic [2:0] prog_echo = 3'd0;
  logic [2:0] prog_code;
  logic       update, busy, err;
  logic [2:0] cur_prog;

  int total = 0;
  int bad = 0;

  int mon_upd = 0, mon_err = 0, mon_both = 0, mon_chg = 0;
  logic [2:0] prev_prog = 3'd0;
  logic       prev_rst = 1'b0;

  dcm_prog_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .MAX_CODE       (3'd6),
    .RESET_PROG     (3'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_load (btn_load),
    .sel_in   (sel_in),
    .prog_echo(prog_echo),
    .prog_code(prog_code),
    .update   (update),
    .busy     (busy),
    .err      (err),
    .cur_prog (cur_prog)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update) mon_upd++;
    if (err) mon_err++;
    if (update && err) mon_both++;
    if (rst && prev_rst && !update && (prog_code !== prev_prog)) mon_chg++;
    prev_prog = prog_code;
    prev_rst  = rst;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_load = 1'b1;
    step(8);
    btn_load = 1'b0;
    step(30);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_load = 1'b1;
    sel_in = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (prog_code !== 3'd0) begin bad++; $display("FAIL reset_prog_code got=%0d exp=0", prog_code); end
      total++; if (cur_prog !== 3'd0) begin bad++; $display("FAIL reset_cur_prog got=%0d exp=0", cur_prog); end
      total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update got=%b exp=0", update); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    end
    @(posedge clk);
    #1;
    btn_load = 1'b0;
    rst = 1'b1;
    step(10);
  endtask

  task automatic test_load();
    int first = -1;
    int n_upd = 0;
    int n_busy = 0;
    int e0 = mon_err;
    sel_in = 3'd5;
    prog_echo = 3'd5;
    btn_load = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (update) begin
        n_upd++;
        if (first < 0) first = k;
      end
      if (busy) n_busy++;
      if (k == 20) btn_load = 1'b0;
    end
    total++; if (first != 8) begin bad++; $display("FAIL load_latency got=%0d exp=8", first); end
    total++; if (n_upd != 1) begin bad++; $display("FAIL load_update_count got=%0d exp=1", n_upd); end
    total++; if (n_busy != EXP_BUSY) begin bad++; $display("FAIL load_busy_cycles got=%0d exp=%0d", n_busy, EXP_BUSY); end
    total++; if (prog_code !== 3'd5) begin bad++; $display("FAIL load_prog_code got=%0d exp=5", prog_code); end
    total++; if (cur_prog !== 3'd5) begin bad++; $display("FAIL load_cur_prog got=%0d exp=5", cur_prog); end
    total++; if (mon_err != e0) begin bad++; $display("FAIL load_err got=%0d exp=0", mon_err - e0); end
  endtask

  task automatic test_bounce();
    int u0 = mon_upd;
    int e0 = mon_err;
    sel_in = 3'd3;
    for (int i = 0; i < 15; i++) begin
      btn_load = ~btn_load;
      step(2);
    end
    btn_load = 1'b0;
    step(20);
    total++; if (mon_upd != u0) begin bad++; $display("FAIL bounce_update got=%0d exp=0", mon_upd - u0); end
    total++; if (mon_err != e0) begin bad++; $display("FAIL bounce_err got=%0d exp=0", mon_err - e0); end
  endtask

  task automatic test_illegal();
    int u0 = mon_upd;
    int e0 = mon_err;
    sel_in = 3'd7;
    press();
    total++; if (mon_err - e0 != 1) begin bad++; $display("FAIL illegal_err_cycles got=%0d exp=1", mon_err - e0); end
    total++; if (mon_upd != u0) begin bad++; $display("FAIL illegal_update got=%0d exp=0", mon_upd - u0); end
    total++; if (prog_code !== 3'd5) begin bad++; $display("FAIL illegal_prog_code got=%0d exp=5", prog_code); end
    total++; if (cur_prog !== 3'd5) begin bad++; $display("FAIL illegal_cur_prog got=%0d exp=5", cur_prog); end
  endtask

  task automatic test_holdoff_same();
    int u0 = mon_upd;
    int e0 = mon_err;
    sel_in = 3'd2;
    prog_echo = 3'd2;
    // first press accepted; the quick re-press lands its request in HOLD
    btn_load = 1'b1;
    step(4);
    btn_load = 1'b0;
    step(4);
    btn_load = 1'b1;
    step(8);
    btn_load = 1'b0;
    step(30);
    total++; if (mon_upd - u0 != 1) begin bad++; $display("FAIL holdoff_update got=%0d exp=1", mon_upd - u0); end
    total++; if (mon_err != e0) begin bad++; $display("FAIL holdoff_err got=%0d exp=0", mon_err - e0); end
    total++; if (cur_prog !== 3'd2) begin bad++; $display("FAIL holdoff_cur_prog got=%0d exp=2", cur_prog); end
    u0 = mon_upd;
    e0 = mon_err;
    press();
    total++; if (mon_upd != u0) begin bad++; $display("FAIL same_code_update got=%0d exp=0", mon_upd - u0); end
    total++; if (mon_err != e0) begin bad++; $display("FAIL same_code_err got=%0d exp=0", mon_err - e0); end
    total++; if (prog_code !== 3'd2) begin bad++; $display("FAIL same_code_prog got=%0d exp=2", prog_code); end
  endtask

`ifdef DCM_PROG_ECHO_CHECK_EN
  task automatic test_echo();
    int u0 = mon_upd;
    int e0 = mon_err;
    sel_in = 3'd4;
    prog_echo = 3'd3;
    press();
    total++; if (mon_err - e0 != 1) begin bad++; $display("FAIL echo_mismatch_err got=%0d exp=1", mon_err - e0); end
    total++; if (mon_upd - u0 != 1) begin bad++; $display("FAIL echo_mismatch_update got=%0d exp=1", mon_upd - u0); end
    total++; if (cur_prog !== 3'd4) begin bad++; $display("FAIL echo_cur_prog got=%0d exp=4", cur_prog); end
    u0 = mon_upd;
    e0 = mon_err;
    sel_in = 3'd1;
    prog_echo = 3'd1;
    press();
    total++; if (mon_err != e0) begin bad++; $display("FAIL echo_match_err got=%0d exp=0", mon_err - e0); end
    total++; if (mon_upd - u0 != 1) begin bad++; $display("FAIL echo_match_update got=%0d exp=1", mon_upd - u0); end
  endtask
`endif

  task automatic test_invariants();
    total++; if (mon_both != 0) begin bad++; $display("FAIL err_with_update got=%0d exp=0", mon_both); end
    total++; if (mon_chg != 0) begin bad++; $display("FAIL prog_code_unstable got=%0d exp=0", mon_chg); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bounce();
    test_illegal();
    test_holdoff_same();
`ifdef DCM_PROG_ECHO_CHECK_EN
    test_echo();
`endif
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
